// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core types and constants: data width, RV32I branch
//                funct3 codes and the PC-stage state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

   localparam int XLEN = 32;

   // RV32I conditional-branch funct3 encodings
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      PC_RUN     = 2'd0,
      PC_HALTED  = 2'd1,
      PC_TRAPPED = 2'd2
   } pc_state_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
//  Module      : branch_cond
//  Description : Resolves an RV32I conditional branch from funct3 and the ALU
//                flags. The ALU performs SUB for BEQ/BNE (zero flag) and
//                SLT/SLTU for the ordered compares (result bit 0).
//  Revision    : 1.0  initial release
// ============================================================================
module branch_cond
   import core_pkg::*;
(
   input  logic       branch,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       alu_lsb,
   output logic       cond
);

   // Condition is only asserted for a branch instruction; reserved codes never take
   always_comb begin
      cond = 1'b0;
      if (branch) begin
         case (funct3)
            F3_BEQ:           cond = zero;
            F3_BNE:           cond = ~zero;
            F3_BLT, F3_BLTU:  cond = alu_lsb;
            F3_BGE, F3_BGEU:  cond = ~alu_lsb;
            default:          cond = 1'b0;
         endcase
      end
   end

endmodule : branch_cond
`default_nettype wire

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_unit
//  Description : Program-counter stage of a single-cycle RV32 core. Holds the
//                PC, selects the next PC (PC+4 / branch / JAL / JALR), halts on
//                request, traps on a misaligned target and counts retirements.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_next_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              CNT_W    = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch,
   input  logic             jump,
   input  logic             jalr,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  alu_result,
   input  logic             zero,
   input  logic             halt_req,
   input  logic             resume,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             taken,
   output logic             halted,
   output logic             trapped,
   output logic [XLEN-1:0]  trap_addr,
   output logic [CNT_W-1:0] retired_cnt
);

   pc_state_t        state_q, state_n;
   logic [XLEN-1:0]  pc_q, pc_n;
   logic [XLEN-1:0]  trap_addr_q, trap_addr_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [XLEN-1:0]  target;
   logic             cond;
   logic             misaligned;
   logic             retire;

   branch_cond u_branch_cond (
      .branch  (branch),
      .funct3  (funct3),
      .zero    (zero),
      .alu_lsb (alu_result[0]),
      .cond    (cond)
   );

   assign pc_plus4 = pc_q + 32'd4;

   // Next-PC selection; JAL beats JALR beats a taken branch
   always_comb begin
      target = pc_plus4;
      if (jump) begin
         target = pc_q + imm;
      end else if (jalr) begin
         target = {alu_result[XLEN-1:1], 1'b0};
      end else if (cond) begin
         target = pc_q + imm;
      end
      taken      = (state_q == PC_RUN) & (jump | jalr | cond);
      misaligned = (target[1:0] != 2'b00);
   end

   // FSM next-state plus PC, trap-address and counter updates
   always_comb begin
      state_n     = state_q;
      pc_n        = pc_q;
      trap_addr_n = trap_addr_q;
      retire      = 1'b0;
      case (state_q)
         PC_RUN: begin
            if (!stall) begin
               // Alignment fault wins over a halt request in the same cycle
               if (misaligned) begin
                  state_n     = PC_TRAPPED;
                  trap_addr_n = target;
               end else if (halt_req) begin
                  state_n = PC_HALTED;
                  pc_n    = pc_plus4;
                  retire  = 1'b1;
               end else begin
                  pc_n   = target;
                  retire = 1'b1;
               end
            end
         end
         PC_HALTED: begin
            if (resume) begin
               state_n = PC_RUN;
            end
         end
         PC_TRAPPED: begin
            state_n = PC_TRAPPED;
         end
         default: begin
            state_n = PC_RUN;
         end
      endcase
      cnt_n = retire ? (cnt_q + CNT_W'(1)) : cnt_q;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= PC_RUN;
      end else begin
         state_q <= state_n;
      end
   end

   // PC, trap address and retire counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         trap_addr_q <= '0;
         cnt_q       <= '0;
      end else begin
         pc_q        <= pc_n;
         trap_addr_q <= trap_addr_n;
         cnt_q       <= cnt_n;
      end
   end

   assign pc          = pc_q;
   assign halted      = (state_q == PC_HALTED);
   assign trapped     = (state_q == PC_TRAPPED);
   assign trap_addr   = trap_addr_q;
   assign retired_cnt = cnt_q;

endmodule : pc_next_unit
`default_nettype wire
